// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus an iterative multiply/divide unit that
// owns the HI/LO registers and stalls the pipeline while it works.
module ex_stage_md #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              valid_in,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] reg_d_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  output logic              stall,
  output logic              valid_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] data_t_out,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [ADDR_W-1:0] reg_probe,
  output logic [DATA_W-1:0] data_probe,
  output logic              write_probe
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB   = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4,  OP_NOR   = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8,  OP_SRL   = 5'd9,  OP_SRA  = 5'd10, OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MULT = 5'd12, OP_MULTU = 5'd13, OP_DIV  = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_MFHI = 5'd16, OP_MFLO  = 5'd17;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  valid_out_q, valid_out_d, reg_write_out_q, reg_write_out_d;
  logic                  mem_read_out_q, mem_read_out_d, mem_write_out_q, mem_write_out_d;
  logic                  mem_to_reg_out_q, mem_to_reg_out_d;
  logic [ADDR_W-1:0]     reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]     alu_out_q, alu_out_d, data_t_out_q, data_t_out_d;

  logic [DATA_W-1:0]     acc_q, acc_d, lo_work_q, lo_work_d, opb_q, opb_d;
  logic                  div_q, div_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;

  logic signed [DATA_W-1:0] a_s, b_s;
  logic [SH_W-1:0]       shamt;
  logic [DATA_W-1:0]     alu_res;
  logic                  legal, md_op, accept;
  logic                  signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;

  logic [DATA_W:0]       mul_sum, div_sh;
  logic                  div_ge;
  logic [DATA_W-1:0]     step_acc, step_lo, quo_fix, rem_fix, fin_hi, fin_lo;
  logic [2*DATA_W-1:0]   prod, prod_fix;

  assign a_s    = a;
  assign b_s    = b;
  assign shamt  = a[SH_W-1:0];
  assign stall  = (state_q == S_BUSY);
  assign accept = we & valid_in & ~stall;

  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    md_op   = 1'b0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOR:   alu_res = ~(a | b);
      OP_SLT:   alu_res = (a_s < b_s) ? ONE : '0;
      OP_SLTU:  alu_res = (a < b) ? ONE : '0;
      OP_SLL:   alu_res = b << shamt;
      OP_SRL:   alu_res = b >> shamt;
      OP_SRA:   alu_res = b_s >>> shamt;
      OP_LUI:   alu_res = b << (DATA_W / 2);
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: md_op = 1'b1;
      OP_MFHI:  alu_res = hi_q;
      OP_MFLO:  alu_res = lo_q;
      default:  legal = 1'b0;
    endcase
  end

  // The iterative unit works on magnitudes; signs are restored on the final step.
  assign signed_op = (op == OP_MULT) | (op == OP_DIV);
  assign a_neg     = signed_op & a[DATA_W-1];
  assign b_neg     = signed_op & b[DATA_W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_work_q[0] ? {1'b0, opb_q} : '0);
    div_sh  = {acc_q, lo_work_q[DATA_W-1]};
    div_ge  = (div_sh >= {1'b0, opb_q});
    if (div_q) begin
      step_acc = div_ge ? (div_sh[DATA_W-1:0] - opb_q) : div_sh[DATA_W-1:0];
      step_lo  = {lo_work_q[DATA_W-2:0], div_ge};
    end else begin
      step_acc = mul_sum[DATA_W:1];
      step_lo  = {mul_sum[0], lo_work_q[DATA_W-1:1]};
    end
    prod     = {step_acc, step_lo};
    prod_fix = q_neg_q ? -prod : prod;
    quo_fix  = div0_q ? '1 : (q_neg_q ? -step_lo : step_lo);
    rem_fix  = r_neg_q ? -step_acc : step_acc;
    fin_hi   = div_q ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
    fin_lo   = div_q ? quo_fix : prod_fix[DATA_W-1:0];
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    hi_d             = hi_q;
    lo_d             = lo_q;
    valid_out_d      = valid_out_q;
    reg_write_out_d  = reg_write_out_q;
    mem_read_out_d   = mem_read_out_q;
    mem_write_out_d  = mem_write_out_q;
    mem_to_reg_out_d = mem_to_reg_out_q;
    reg_addr_d       = reg_addr_q;
    alu_out_d        = alu_out_q;
    data_t_out_d     = data_t_out_q;
    acc_d            = acc_q;
    lo_work_d        = lo_work_q;
    opb_d            = opb_q;
    div_d            = div_q;
    q_neg_d          = q_neg_q;
    r_neg_d          = r_neg_q;
    div0_d           = div0_q;
    if (we) begin
      if (accept) begin
        valid_out_d      = 1'b1;
        reg_write_out_d  = reg_write_in & legal & ~md_op;
        mem_read_out_d   = mem_read_in;
        mem_write_out_d  = mem_write_in;
        mem_to_reg_out_d = mem_to_reg_in;
        reg_addr_d       = reg_d_in;
        alu_out_d        = alu_res;
        data_t_out_d     = b;
      end else begin
        valid_out_d     = 1'b0;
        reg_write_out_d = 1'b0;
      end
      if (state_q == S_IDLE) begin
        if (accept && md_op) begin
          state_d   = S_BUSY;
          cnt_d     = CNT_W'(DATA_W);
          acc_d     = '0;
          lo_work_d = a_mag;
          opb_d     = b_mag;
          div_d     = (op == OP_DIV) | (op == OP_DIVU);
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          div0_d    = (b == '0);
        end
      end else begin
        acc_d     = step_acc;
        lo_work_d = step_lo;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      valid_out_q      <= 1'b0;
      reg_write_out_q  <= 1'b0;
      mem_read_out_q   <= 1'b0;
      mem_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
      reg_addr_q       <= '0;
      alu_out_q        <= '0;
      data_t_out_q     <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      hi_q             <= hi_d;
      lo_q             <= lo_d;
      valid_out_q      <= valid_out_d;
      reg_write_out_q  <= reg_write_out_d;
      mem_read_out_q   <= mem_read_out_d;
      mem_write_out_q  <= mem_write_out_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
      reg_addr_q       <= reg_addr_d;
      alu_out_q        <= alu_out_d;
      data_t_out_q     <= data_t_out_d;
    end
  end

  // Working operands are only meaningful while BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    lo_work_q <= lo_work_d;
    opb_q     <= opb_d;
    div_q     <= div_d;
    q_neg_q   <= q_neg_d;
    r_neg_q   <= r_neg_d;
    div0_q    <= div0_d;
  end

  assign valid_out      = valid_out_q;
  assign reg_write_out  = reg_write_out_q;
  assign mem_read_out   = mem_read_out_q;
  assign mem_write_out  = mem_write_out_q;
  assign mem_to_reg_out = mem_to_reg_out_q;
  assign reg_addr       = reg_addr_q;
  assign alu_out        = alu_out_q;
  assign data_t_out     = data_t_out_q;
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign reg_probe      = reg_addr_q;
  assign data_probe     = alu_out_q;
  assign write_probe    = valid_out_q & reg_write_out_q & ~mem_to_reg_out_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: arithmetic reference model compared every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        reset, we, valid_in;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [4:0]  reg_d_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        stall, valid_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
  logic [4:0]  reg_addr, reg_probe;
  logic [31:0] alu_out, data_t_out, hi, lo, data_probe;
  logic        write_probe;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  ex_stage_md #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .we(we), .valid_in(valid_in), .op(op), .a(a), .b(b),
    .reg_d_in(reg_d_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .stall(stall),
    .valid_out(valid_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out), .reg_addr(reg_addr),
    .alu_out(alu_out), .data_t_out(data_t_out), .hi(hi), .lo(lo), .reg_probe(reg_probe),
    .data_probe(data_probe), .write_probe(write_probe)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_model(input logic [4:0] o, input logic [31:0] x, y, h, l);
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return ~(x | y);
      5'd6:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      5'd7:  return (x < y) ? 32'd1 : 32'd0;
      5'd8:  return y << x[4:0];
      5'd9:  return y >> x[4:0];
      5'd10: return $signed(y) >>> x[4:0];
      5'd11: return {y[15:0], 16'h0000};
      5'd16: return h;
      5'd17: return l;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {hi, lo}.
  function automatic logic [63:0] md_model(input logic [4:0] o, input logic [31:0] x, y);
    longint sx, sy;
    logic signed [31:0] qs, rs;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      5'd12: return 64'(sx * sy);
      5'd13: return {32'h0, x} * {32'h0, y};
      5'd14: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        return {rs, qs};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
  logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_mtr = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_alu = '0, m_dt = '0;
  logic        m_accept, m_is_md;

  assign m_accept = we & valid_in & (m_left == 0);
  assign m_is_md  = (op >= 5'd12) && (op <= 5'd15);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0;
      m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_mtr <= 0;
      m_addr <= '0; m_alu <= '0; m_dt <= '0;
    end else if (we) begin
      if (m_accept) begin
        m_valid <= 1'b1;
        m_rw    <= reg_write_in && (op <= 5'd17) && !m_is_md;
        m_mr    <= mem_read_in;
        m_mw    <= mem_write_in;
        m_mtr   <= mem_to_reg_in;
        m_addr  <= reg_d_in;
        m_alu   <= alu_model(op, a, b, m_hi, m_lo);
        m_dt    <= b;
        if (m_is_md) begin
          m_left <= 32;
          {m_pend_hi, m_pend_lo} <= md_model(op, a, b);
        end
      end else begin
        m_valid <= 1'b0;
        m_rw    <= 1'b0;
      end
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_pend_hi;
          m_lo <= m_pend_lo;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",          64'(stall),          64'(m_left != 0));
      check("valid_out",      64'(valid_out),      64'(m_valid));
      check("reg_write_out",  64'(reg_write_out),  64'(m_rw));
      check("mem_read_out",   64'(mem_read_out),   64'(m_mr));
      check("mem_write_out",  64'(mem_write_out),  64'(m_mw));
      check("mem_to_reg_out", 64'(mem_to_reg_out), 64'(m_mtr));
      check("reg_addr",       64'(reg_addr),       64'(m_addr));
      check("alu_out",        64'(alu_out),        64'(m_alu));
      check("data_t_out",     64'(data_t_out),     64'(m_dt));
      check("hi",             64'(hi),             64'(m_hi));
      check("lo",             64'(lo),             64'(m_lo));
      check("reg_probe",      64'(reg_probe),      64'(m_addr));
      check("data_probe",     64'(data_probe),     64'(m_alu));
      check("write_probe",    64'(write_probe),    64'(m_valid & m_rw & ~m_mtr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] o, input logic [31:0] x, y, input logic [4:0] rd);
    op = o; a = x; b = y; reg_d_in = rd;
    reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (stall && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    logic [4:0] o;
    reset = 1'b1; we = 1'b1; valid_in = 1'b0; op = '0; a = '0; b = '0; reg_d_in = '0;
    reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_stall",     64'(stall),     64'd0);
    check("rst_alu_out",   64'(alu_out),   64'd0);
    check("rst_hi_lo",     {hi, lo},       64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    drive(5'd0, 32'hFFFFFFFF, 32'h1, 5'd3);
    check("add_alu",   64'(alu_out),     64'h0);
    check("add_addr",  64'(reg_addr),    64'd3);
    check("add_probe", 64'(write_probe), 64'd1);

    drive(5'd12, 32'hFFFFFFFE, 32'h3, 5'd4);
    check("mult_vo", 64'({valid_out, reg_write_out}), 64'b10);
    wait_idle(cyc);
    check("mult_stall_cycles", 64'(cyc), 64'd32);
    check("mult_hi", 64'(hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo), 64'hFFFFFFFA);
    drive(5'd17, 32'h0, 32'h0, 5'd5);
    check("mflo", 64'(alu_out), 64'hFFFFFFFA);

    drive(5'd14, 32'hFFFFFFF9, 32'h2, 5'd6);
    wait_idle(cyc);
    check("div_lo", 64'(lo), 64'hFFFFFFFD);
    check("div_hi", 64'(hi), 64'hFFFFFFFF);
    drive(5'd15, 32'h7, 32'h0, 5'd6);
    wait_idle(cyc);
    check("divu0_lo", 64'(lo), 64'hFFFFFFFF);
    check("divu0_hi", 64'(hi), 64'h7);
    drive(5'd14, 32'h80000000, 32'hFFFFFFFF, 5'd6);
    wait_idle(cyc);
    check("divmin_lo", 64'(lo), 64'h80000000);
    check("divmin_hi", 64'(hi), 64'h0);

    drive(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    cyc = 0;
    while (stall && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) we = 1'b0;
      if (cyc == 15) we = 1'b1;
    end
    we = 1'b1;
    check("multu_stall_cycles", 64'(cyc), 64'd37);
    check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    drive(5'd12, 32'h5, 32'h6, 5'd8);
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_rst", 64'(stall), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_hilo",  {hi, lo},   64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("after_abort_hilo",  {hi, lo},   64'd0);
    check("after_abort_stall", 64'(stall), 64'd0);

    drive(5'd10, 32'h4, 32'h80000000, 5'd9);
    check("sra", 64'(alu_out), 64'hF8000000);
    drive(5'd11, 32'h0, 32'h1234, 5'd9);
    check("lui", 64'(alu_out), 64'h12340000);
    drive(5'd7, 32'h1, 32'hFFFFFFFF, 5'd9);
    check("sltu", 64'(alu_out), 64'h1);
    drive(5'd20, 32'h1, 32'h2, 5'd9);
    check("illegal_rw", 64'({valid_out, reg_write_out, alu_out}), {32'h0, 2'b10, 32'h0});

    for (int i = 0; i < 3000; i++) begin
      we       = ($urandom_range(0, 9) != 0);
      valid_in = ($urandom_range(0, 3) != 0);
      o = 5'($urandom_range(0, 19));
      if (o >= 5'd12 && o <= 5'd15 && $urandom_range(0, 2) != 0) o = 5'($urandom_range(0, 11));
      op = o; a = pick(); b = pick();
      reg_d_in = 5'($urandom);
      reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
      mem_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom);
      reset = ($urandom_range(0, 399) != 0);
      @(posedge clk); #1;
    end
    reset = 1'b1; we = 1'b1; valid_in = 1'b0;
    wait_idle(cyc);
    check("final_idle", 64'(stall), 64'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
EX_STAGE_MD -- requirements
Module: ex_stage_md

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values are even and at least 8.
REQ-002 Parameter ADDR_W, default 5, register-address width.
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port we, input, 1, global pipeline enable; when 0 all state holds.
REQ-006 Port valid_in, input, 1, an instruction is presented.
REQ-007 Port op, input, 5, operation code (REQ-014).
REQ-008 Ports a and b, input, DATA_W, source operands.
REQ-009 Ports reg_d_in, input, ADDR_W; reg_write_in, mem_read_in, mem_write_in and mem_to_reg_in, input, 1 each; sideband passed downstream.
REQ-010 Port stall, output, 1, multiply/divide unit busy; upstream holds its inputs.
REQ-011 Ports valid_out, reg_write_out, mem_read_out, mem_write_out and mem_to_reg_out, output, 1 each, registered; reg_addr, output, ADDR_W, registered; alu_out and data_t_out, output, DATA_W, registered.
REQ-012 Ports hi and lo, output, DATA_W, architectural HI/LO registers.
REQ-013 Ports reg_probe (ADDR_W), data_probe (DATA_W) and write_probe (1), output, combinational forward probe.

Function
REQ-014 Op encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
- 8 SLL, 9 SRL, 10 SRA, 11 LUI
- 12 MULT, 13 MULTU, 14 DIV, 15 DIVU, 16 MFHI, 17 MFLO
- all other codes: result 0, reg_write_out forced to 0.
REQ-015 Arithmetic is modulo 2^DATA_W with no overflow trap; SLT is signed; SLTU is unsigned; each yields 1 or 0.
REQ-016 Shifts shift b by a[log2(DATA_W)-1:0]; LUI yields b << (DATA_W/2).
REQ-017 Accept condition: we=1, valid_in=1 and stall=0. On accept, output registers load the result and sideband on the next edge, and data_t_out=b; latency is 1 cycle.
REQ-018 When we=1 and no instruction is accepted, valid_out and reg_write_out load 0 (bubble).
REQ-019 When we=0, all registers, the counter and the FSM hold.
REQ-020 MD FSM states:
- IDLE: an accepted op 12-15 latches operands and the signed/divide mode, loads counter=DATA_W and moves to BUSY.
- BUSY: each we=1 cycle performs one shift-add or restoring-divide step and decrements the counter.
- At counter 1, that edge writes hi/lo and returns to IDLE.
REQ-021 stall=1 exactly while in BUSY, for DATA_W enabled cycles after the accepting edge.
REQ-022 An accepted op 12-15 itself emits valid_out=1 and reg_write_out=0.
REQ-023 MULT/MULTU: {hi,lo} = full 2*DATA_W product.
REQ-024 DIV/DIVU: lo = quotient, hi = remainder. Signed ops use magnitudes, then fix signs: quotient negative if the operand signs differ; remainder takes the dividend's sign.
REQ-025 Divide by zero: lo = all ones, hi = a.
REQ-026 Signed MIN / -1: lo = MIN, hi = 0.
REQ-027 MFHI/MFLO return the current hi/lo; they cannot be accepted while BUSY, so they always see completed results.
REQ-028 Forward probe:
- reg_probe = reg_addr
- data_probe = alu_out
- write_probe = valid_out & reg_write_out & ~mem_to_reg_out.
REQ-029 A write to register 0 passes through unchanged; filtering it is the register file's job.

Reset
REQ-030 reset=0 asynchronously clears all output registers, hi, lo and the counter, and sets the FSM to IDLE (stall=0).
REQ-031 Reset during BUSY aborts the operation; hi/lo read 0 and no late write occurs after release.
REQ-032 Outputs leave reset values only on the first rising clk edge after reset returns to 1.

Verification
REQ-033 The bench SHALL cover these directed scenarios at DATA_W=32:
- ADD, a=0xFFFFFFFF, b=1, reg_d_in=3 -> next cycle alu_out=0, reg_addr=3, write_probe=1.
- MULT, a=0xFFFFFFFE (-2), b=3 -> stall high for exactly 32 enabled cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; a following MFLO yields 0xFFFFFFFA.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- MULTU, with we dropped to 0 for 5 cycles mid-operation -> stall lasts 37 cycles; result is unchanged.
- reset asserted on the 10th BUSY cycle -> stall=0 and hi=lo=0 immediately; both stay 0 after release.
- SRA, a=4, b=0x80000000 -> 0xF8000000. LUI, b=0x1234 -> 0x12340000. SLTU, a=1, b=0xFFFFFFFF -> 1.
